calc_entry_ctrl: RTL and testbench

- Keypad-entry sequencer for the calculator's 4-digit BCD display register. The display register has 4-bit digits dig3..dig0 and is driven by a 3-bit sel code plus a char/is_number strobe.
- Turns decoded key events into a two-digit operand A, an operator, and a two-digit operand B.
- Issues one register command per accepted key, latches the operator, and pulses calc_go to the ALU stage on enter.
- Sits between the keyboard decoder and the digit register/ALU.

---
 rtl/calc_entry_ctrl.sv | 145 ++++++++++++++
 tb/tb_calc_entry_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_entry_ctrl.sv
// Keypad-entry sequencer: turns decoded key events into digit-register commands,
// a latched operator and a calc_go pulse for the ALU stage.
module calc_entry_ctrl #(
    parameter int unsigned IDLE_TIMEOUT = 0,
    parameter logic [2:0]  SEL_HOLD     = 3'd7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       key_ready,
    output logic [2:0] sel,
    output logic [3:0] char,
    output logic       is_number,
    output logic [1:0] op,
    output logic       calc_go,
    output logic       result_valid
);
    typedef enum logic [2:0] {
        S_IDLE, S_A1, S_A2, S_OP, S_B1, S_B2, S_DONE, S_RESTART
    } state_t;

    state_t      state_q;
    logic [3:0]  stored_q;
    logic [31:0] timer_q;
    logic        key_ready_q, is_number_q, calc_go_q, result_valid_q;
    logic [2:0]  sel_q;
    logic [3:0]  char_q;
    logic [1:0]  op_q;

    logic        accept, is_digit, is_oper, is_enter, is_clear, expire;
    logic [31:0] timer_inc;
    logic [1:0]  op_code;

    // Code 15 never counts as accepted, so it cannot reload the timer either.
    assign accept    = key_valid && key_ready_q && (key_code != 4'd15);
    assign is_digit  = (key_code <= 4'd9);
    assign is_oper   = (key_code >= 4'd10) && (key_code <= 4'd12);
    assign is_enter  = (key_code == 4'd13);
    assign is_clear  = (key_code == 4'd14);
    assign op_code   = key_code[1:0] + 2'd3;
    assign timer_inc = (timer_q == 32'hFFFF_FFFF) ? timer_q : timer_q + 32'd1;
    assign expire    = (IDLE_TIMEOUT != 0) && (state_q != S_IDLE) && !accept
                       && (timer_inc >= IDLE_TIMEOUT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            stored_q       <= 4'd0;
            timer_q        <= 32'd0;
            key_ready_q    <= 1'b1;
            sel_q          <= SEL_HOLD;
            char_q         <= 4'd0;
            is_number_q    <= 1'b0;
            op_q           <= 2'd0;
            calc_go_q      <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            sel_q       <= SEL_HOLD;
            char_q      <= 4'd0;
            is_number_q <= 1'b0;
            calc_go_q   <= 1'b0;
            key_ready_q <= 1'b1;

            if (accept || expire)
                timer_q <= 32'd0;
            else if (state_q != S_IDLE)
                timer_q <= timer_inc;

            if (expire) begin
                sel_q          <= 3'd0;
                op_q           <= 2'd0;
                result_valid_q <= 1'b0;
                state_q        <= S_IDLE;
            end else if (state_q == S_RESTART) begin
                sel_q       <= 3'd1;
                char_q      <= stored_q;
                is_number_q <= 1'b1;
                op_q        <= 2'd0;
                state_q     <= S_A1;
            end else if (accept && is_clear) begin
                sel_q          <= 3'd0;
                op_q           <= 2'd0;
                result_valid_q <= 1'b0;
                state_q        <= S_IDLE;
            end else if (accept) begin
                unique case (state_q)
                    S_IDLE, S_A1, S_A2: begin
                        if (is_oper) begin
                            sel_q   <= 3'd3;
                            op_q    <= op_code;
                            state_q <= S_OP;
                        end else if (is_digit && state_q != S_A2) begin
                            sel_q       <= (state_q == S_IDLE) ? 3'd1 : 3'd2;
                            char_q      <= key_code;
                            is_number_q <= 1'b1;
                            state_q     <= (state_q == S_IDLE) ? S_A1 : S_A2;
                        end
                    end
                    S_OP: begin
                        if (is_oper) begin
                            op_q <= op_code;
                        end else if (is_digit) begin
                            sel_q       <= 3'd4;
                            char_q      <= key_code;
                            is_number_q <= 1'b1;
                            state_q     <= S_B1;
                        end
                    end
                    S_B1, S_B2: begin
                        if (is_enter) begin
                            calc_go_q      <= 1'b1;
                            result_valid_q <= 1'b1;
                            state_q        <= S_DONE;
                        end else if (is_digit && state_q == S_B1) begin
                            sel_q       <= 3'd5;
                            char_q      <= key_code;
                            is_number_q <= 1'b1;
                            state_q     <= S_B2;
                        end
                    end
                    S_DONE: begin
                        // The digit is replayed as the first A digit once the display is cleared.
                        if (is_digit) begin
                            stored_q       <= key_code;
                            sel_q          <= 3'd0;
                            key_ready_q    <= 1'b0;
                            result_valid_q <= 1'b0;
                            state_q        <= S_RESTART;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign key_ready    = key_ready_q;
    assign sel          = sel_q;
    assign char         = char_q;
    assign is_number    = is_number_q;
    assign op           = op_q;
    assign calc_go      = calc_go_q;
    assign result_valid = result_valid_q;
endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Bench for calc_entry_ctrl: directed scenarios plus randomized keys checked
// against an operand-counting reference model.
module tb_calc_entry_ctrl;
    localparam int unsigned TO = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'd15;
    logic       key_ready, is_number, calc_go, result_valid;
    logic [2:0] sel;
    logic [3:0] char;
    logic [1:0] op;

    int vectors = 0;
    int miscompares = 0;

    calc_entry_ctrl #(.IDLE_TIMEOUT(TO), .SEL_HOLD(3'd7)) dut (
        .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
        .key_ready(key_ready), .sel(sel), .char(char), .is_number(is_number),
        .op(op), .calc_go(calc_go), .result_valid(result_valid)
    );

    always #5 clk = ~clk;

    // Reference model: tracks how many digits each operand holds and whether
    // an operator / result / pending restart exists.
    int          m_a, m_b;
    bit          m_opseen, m_done, m_pend;
    logic [3:0]  m_stored;
    int unsigned m_timer;
    logic [2:0]  e_sel;
    logic [3:0]  e_char;
    logic [1:0]  e_op;
    bit          e_num, e_go, e_rv, e_ready;

    function automatic void model_clear();
        m_a = 0; m_b = 0; m_opseen = 0; m_done = 0; m_pend = 0;
    endfunction

    function automatic void model_reset();
        model_clear();
        m_stored = 0; m_timer = 0;
        e_sel = 7; e_char = 0; e_op = 0; e_num = 0; e_go = 0; e_rv = 0; e_ready = 1;
    endfunction

    function automatic void model_step(input bit kv, input logic [3:0] kc);
        bit acc, idle;
        acc  = kv && e_ready && (kc != 15);
        idle = (m_a == 0) && !m_opseen && !m_done && !m_pend;
        e_sel = 7; e_char = 0; e_num = 0; e_go = 0;
        if (!acc && !idle && (m_timer + 1 >= TO)) begin
            e_sel = 0; e_op = 0; model_clear(); m_timer = 0;
        end else if (m_pend) begin
            e_sel = 1; e_char = m_stored; e_num = 1; e_op = 0;
            model_clear(); m_a = 1; m_timer++;
        end else if (acc) begin
            m_timer = 0;
            if (kc == 14) begin
                e_sel = 0; e_op = 0; model_clear();
            end else if (kc <= 9) begin
                if (m_done) begin
                    m_stored = kc; e_sel = 0; m_done = 0; m_pend = 1;
                end else if (m_opseen) begin
                    if (m_b < 2) begin
                        e_sel = (m_b == 0) ? 3'd4 : 3'd5; e_char = kc; e_num = 1; m_b++;
                    end
                end else if (m_a < 2) begin
                    e_sel = (m_a == 0) ? 3'd1 : 3'd2; e_char = kc; e_num = 1; m_a++;
                end
            end else if (kc <= 12) begin
                if (!m_done && m_b == 0) begin
                    e_op = 2'(kc - 9);
                    if (!m_opseen) begin e_sel = 3; m_opseen = 1; end
                end
            end else if (m_opseen && m_b > 0 && !m_done) begin
                e_go = 1; m_done = 1;
            end
        end else if (!idle) begin
            m_timer++;
        end
        e_ready = !m_pend;
        e_rv    = m_done;
    endfunction

    task automatic tick(input bit kv, input logic [3:0] kc);
        key_valid = kv;
        key_code  = kc;
        @(posedge clk);
        model_step(kv, kc);
        #1;
        if (kv)
            $display("key %0d -> sel=%0d char=%0d num=%0d op=%0d go=%0d rv=%0d ready=%0d",
                     kc, sel, char, is_number, op, calc_go, result_valid, key_ready);
        key_valid = 1'b0;
        key_code  = 4'd15;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        vectors++;
        if (sel !== 3'd7 || char !== 4'd0 || is_number !== 1'b0 || op !== 2'd0 ||
            calc_go !== 1'b0 || result_valid !== 1'b0 || key_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset: sel=%0d char=%0d num=%0d op=%0d go=%0d rv=%0d ready=%0d, want 7/0/0/0/0/0/1",
                     sel, char, is_number, op, calc_go, result_valid, key_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic_entry();
        logic [3:0] keys [6] = '{4'd4, 4'd2, 4'd10, 4'd1, 4'd7, 4'd13};
        logic [2:0] xs   [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd7};
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, keys[i]);
            vectors++;
            if (sel !== xs[i] || (xs[i] != 3 && xs[i] != 7 && char !== keys[i])
                || is_number !== (xs[i] != 3 && xs[i] != 7)) begin
                miscompares++;
                $display("FAIL basic_cmd%0d: sel=%0d char=%0d num=%0d, want sel=%0d char=%0d",
                         i, sel, char, is_number, xs[i], keys[i]);
            end
        end
        vectors++;
        if (op !== 2'd1 || calc_go !== 1'b1 || result_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_go: op=%0d go=%0d rv=%0d, want 1/1/1", op, calc_go, result_valid);
        end
        tick(1'b0, 4'd15);
        vectors++;
        if (calc_go !== 1'b0 || result_valid !== 1'b1 || op !== 2'd1) begin
            miscompares++;
            $display("FAIL basic_pulse: go=%0d rv=%0d op=%0d, want 0/1/1", calc_go, result_valid, op);
        end
    endtask

    task automatic test_a2_limit();
        tick(1'b1, 4'd14);
        tick(1'b1, 4'd4);
        tick(1'b1, 4'd2);
        tick(1'b1, 4'd9);
        vectors++;
        if (sel !== 3'd7 || is_number !== 1'b0) begin
            miscompares++;
            $display("FAIL a2_limit: sel=%0d num=%0d, want 7/0", sel, is_number);
        end
        tick(1'b1, 4'd12);
        vectors++;
        if (sel !== 3'd3 || op !== 2'd3) begin
            miscompares++;
            $display("FAIL op_first: sel=%0d op=%0d, want 3/3", sel, op);
        end
        tick(1'b1, 4'd11);
        vectors++;
        if (sel !== 3'd7 || op !== 2'd2) begin
            miscompares++;
            $display("FAIL op_overwrite: sel=%0d op=%0d, want 7/2", sel, op);
        end
    endtask

    task automatic test_restart();
        tick(1'b1, 4'd1);
        tick(1'b1, 4'd13);
        tick(1'b1, 4'd5);
        vectors++;
        if (sel !== 3'd0 || key_ready !== 1'b0 || result_valid !== 1'b0 || op !== 2'd2) begin
            miscompares++;
            $display("FAIL restart_t1: sel=%0d ready=%0d rv=%0d op=%0d, want 0/0/0/2",
                     sel, key_ready, result_valid, op);
        end
        tick(1'b1, 4'd3);
        vectors++;
        if (sel !== 3'd1 || char !== 4'd5 || is_number !== 1'b1 || op !== 2'd0 || key_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL restart_t2: sel=%0d char=%0d num=%0d op=%0d ready=%0d, want 1/5/1/0/1",
                     sel, char, is_number, op, key_ready);
        end
        tick(1'b0, 4'd15);
        tick(1'b1, 4'd6);
        vectors++;
        if (sel !== 3'd2 || char !== 4'd6) begin
            miscompares++;
            $display("FAIL restart_drop: sel=%0d char=%0d, want 2/6", sel, char);
        end
    endtask

    task automatic test_clear();
        tick(1'b1, 4'd10);
        tick(1'b1, 4'd8);
        tick(1'b1, 4'd14);
        vectors++;
        if (sel !== 3'd0 || op !== 2'd0 || is_number !== 1'b0) begin
            miscompares++;
            $display("FAIL clear_b1: sel=%0d op=%0d num=%0d, want 0/0/0", sel, op, is_number);
        end
        tick(1'b1, 4'd13);
        vectors++;
        if (calc_go !== 1'b0 || sel !== 3'd7 || result_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL enter_idle: go=%0d sel=%0d rv=%0d, want 0/7/0", calc_go, sel, result_valid);
        end
    endtask

    task automatic test_timeout();
        tick(1'b1, 4'd3);
        for (int i = 0; i < 7; i++) tick(1'b0, 4'd15);
        vectors++;
        if (sel !== 3'd7) begin
            miscompares++;
            $display("FAIL timeout_early: sel=%0d, want 7", sel);
        end
        tick(1'b0, 4'd15);
        vectors++;
        if (sel !== 3'd0 || op !== 2'd0) begin
            miscompares++;
            $display("FAIL timeout_fire: sel=%0d op=%0d, want 0/0", sel, op);
        end
        tick(1'b1, 4'd3);
        for (int i = 0; i < 7; i++) tick(1'b0, 4'd15);
        tick(1'b1, 4'd6);
        vectors++;
        if (sel !== 3'd2 || char !== 4'd6) begin
            miscompares++;
            $display("FAIL timeout_key_wins: sel=%0d char=%0d, want 2/6", sel, char);
        end
        tick(1'b0, 4'd15);
        vectors++;
        if (sel !== 3'd7) begin
            miscompares++;
            $display("FAIL timeout_reload: sel=%0d, want 7", sel);
        end
    endtask

    task automatic test_reset_restart();
        tick(1'b1, 4'd10);
        tick(1'b1, 4'd1);
        tick(1'b1, 4'd13);
        tick(1'b1, 4'd5);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        vectors++;
        if (sel !== 3'd7 || op !== 2'd0 || key_ready !== 1'b1 || result_valid !== 1'b0 ||
            calc_go !== 1'b0 || is_number !== 1'b0 || char !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_restart: sel=%0d op=%0d ready=%0d rv=%0d go=%0d num=%0d char=%0d, want 7/0/1/0/0/0/0",
                     sel, op, key_ready, result_valid, calc_go, is_number, char);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick(1'b0, 4'd15);
            vectors++;
            if (sel !== 3'd7 || is_number !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_no_replay%0d: sel=%0d num=%0d, want 7/0", i, sel, is_number);
            end
        end
    endtask

    task automatic test_random();
        int burst = 0;
        for (int n = 0; n < 400; n++) begin
            bit kv;
            logic [3:0] kc;
            int r;
            if (burst > 0) begin
                burst--; kv = 0; kc = 15;
            end else begin
                if ($urandom_range(0, 29) == 0) burst = $urandom_range(6, 10);
                kv = ($urandom_range(0, 99) < 60);
                r  = $urandom_range(0, 99);
                kc = (r < 55) ? 4'($urandom_range(0, 9)) :
                     (r < 72) ? 4'($urandom_range(10, 12)) :
                     (r < 85) ? 4'd13 : (r < 91) ? 4'd14 : 4'd15;
            end
            tick(kv, kc);
            vectors++;
            if (sel !== e_sel || is_number !== e_num || (e_num && char !== e_char) || op !== e_op ||
                calc_go !== e_go || result_valid !== e_rv || key_ready !== e_ready) begin
                miscompares++;
                $display("FAIL random%0d: got sel=%0d char=%0d num=%0d op=%0d go=%0d rv=%0d rdy=%0d, want %0d/%0d/%0d/%0d/%0d/%0d/%0d",
                         n, sel, char, is_number, op, calc_go, result_valid, key_ready,
                         e_sel, e_char, e_num, e_op, e_go, e_rv, e_ready);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic_entry();
        test_a2_limit();
        test_restart();
        test_clear();
        test_timeout();
        test_reset_restart();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
